// File: rtl/game_sequencer.sv
// Run controller for the bouncing-ball game: sequences idle/clear/play/pause/over,
// gates the frame-rate generator, resets the datapath and keeps score and speed.
module game_sequencer #(
  parameter int APPLES_PER_LEVEL = 5,
  parameter int SPEED_MIN        = 1,
  parameter int SPEED_MAX        = 7,
  parameter int RST_PULSE_CYCLES = 4,
  parameter int OVER_HOLD_CYCLES = 50000000
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       startButton,
  input  logic       pauseButton,
  input  logic       BALL_clk,
  input  logic       hitApple,
  input  logic       gameOverFlag,
  output logic       startGame,
  output logic       gameRst_n,
  output logic [2:0] Speed,
  output logic [7:0] score,
  output logic [7:0] highScore,
  output logic [2:0] gameState
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [25:0] HOLD_MAX   = 26'(OVER_HOLD_CYCLES);
  localparam logic [7:0]  RST_LAST   = 8'(RST_PULSE_CYCLES - 1);
  localparam logic [7:0]  APPLE_LAST = 8'(APPLES_PER_LEVEL - 1);
  localparam logic [2:0]  SPD_MIN    = 3'(SPEED_MIN);
  localparam logic [2:0]  SPD_MAX    = 3'(SPEED_MAX);

  logic        ballSync1, ballSync2, ballPrev;
  logic        startPrev, pausePrev;
  logic        frameTick, startEdge, pauseEdge, enterClear;
  logic [7:0]  appleCnt;
  logic [7:0]  rstCnt;
  logic [25:0] holdCnt;

  // BALL_clk is treated as data: synchronised, then edge-detected into a one-cycle tick.
  assign frameTick = ballSync2 & ~ballPrev;
  assign startEdge = startButton & ~startPrev;
  assign pauseEdge = pauseButton & ~pausePrev;
  assign startGame = (gameState == S_PLAY);
  assign enterClear = startEdge &&
                      ((gameState == S_IDLE) ||
                       ((gameState == S_OVER) && (holdCnt == HOLD_MAX)));

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      gameState <= S_IDLE;
      gameRst_n <= 1'b1;
      Speed     <= SPD_MIN;
      score     <= 8'd0;
      highScore <= 8'd0;
      appleCnt  <= 8'd0;
      rstCnt    <= 8'd0;
      holdCnt   <= 26'd0;
      ballSync1 <= 1'b0;
      ballSync2 <= 1'b0;
      ballPrev  <= 1'b0;
      startPrev <= 1'b0;
      pausePrev <= 1'b0;
    end else begin
      ballSync1 <= BALL_clk;
      ballSync2 <= ballSync1;
      ballPrev  <= ballSync2;
      startPrev <= startButton;
      pausePrev <= pauseButton;

      case (gameState)
        S_IDLE: ;
        S_CLEAR: begin
          if (rstCnt == RST_LAST) begin
            gameState <= S_PLAY;
            gameRst_n <= 1'b1;
          end else begin
            rstCnt <= rstCnt + 8'd1;
          end
        end
        S_PLAY: begin
          if (frameTick && gameOverFlag) begin
            gameState <= S_OVER;
            holdCnt   <= 26'd0;
            if (score > highScore) highScore <= score;
          end else begin
            if (frameTick && hitApple) begin
              if (score != 8'hFF) score <= score + 8'd1;
              if (appleCnt == APPLE_LAST) begin
                appleCnt <= 8'd0;
                if (Speed < SPD_MAX) Speed <= Speed + 3'd1;
              end else begin
                appleCnt <= appleCnt + 8'd1;
              end
            end
            // A pause landing on a tick still lets that tick be scored first.
            if (pauseEdge) gameState <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pauseEdge || startEdge) gameState <= S_PLAY;
        end
        S_OVER: begin
          if (holdCnt != HOLD_MAX) holdCnt <= holdCnt + 26'd1;
        end
        default: gameState <= S_IDLE;
      endcase

      if (enterClear) begin
        gameState <= S_CLEAR;
        gameRst_n <= 1'b0;
        rstCnt    <= 8'd0;
        score     <= 8'd0;
        Speed     <= SPD_MIN;
        appleCnt  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: frame vector table plus hand-written
// sequences for clear pulse, pause, game-over hold and mid-clear reset.
module tb_game_sequencer;

  logic       master_clk;
  logic       rst;
  logic       startButton, pauseButton, BALL_clk, hitApple, gameOverFlag;
  logic       startGame, gameRst_n;
  logic [2:0] Speed, gameState;
  logic [7:0] score, highScore;

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {
    bit         hit;
    bit         over;
    logic [2:0] expState;
    logic [7:0] expScore;
    logic [2:0] expSpeed;
  } frameVec_t;

  frameVec_t vecs[7];

  game_sequencer #(
    .APPLES_PER_LEVEL(5),
    .SPEED_MIN(1),
    .SPEED_MAX(7),
    .RST_PULSE_CYCLES(4),
    .OVER_HOLD_CYCLES(20)
  ) dut (
    .master_clk(master_clk),
    .rst(rst),
    .startButton(startButton),
    .pauseButton(pauseButton),
    .BALL_clk(BALL_clk),
    .hitApple(hitApple),
    .gameOverFlag(gameOverFlag),
    .startGame(startGame),
    .gameRst_n(gameRst_n),
    .Speed(Speed),
    .score(score),
    .highScore(highScore),
    .gameState(gameState)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pressStart();
    @(negedge master_clk) startButton = 1'b1;
    @(negedge master_clk) startButton = 1'b0;
  endtask

  task automatic pressPause();
    @(negedge master_clk) pauseButton = 1'b1;
    @(negedge master_clk) pauseButton = 1'b0;
  endtask

  task automatic frame(input bit hit, input bit over);
    @(negedge master_clk);
    hitApple     = hit;
    gameOverFlag = over;
    BALL_clk     = 1'b1;
    repeat (3) @(negedge master_clk);
    BALL_clk     = 1'b0;
    gameOverFlag = 1'b0;
    repeat (3) @(negedge master_clk);
  endtask

  // Waits out the CLEAR pulse and returns how many sampled cycles gameRst_n was low.
  task automatic countClear(output int lowCnt);
    lowCnt = 0;
    for (int i = 0; i < 20 && gameRst_n == 1'b0; i++) begin
      lowCnt++;
      @(negedge master_clk);
    end
  endtask

  // Enters OVER via a tick carrying both hit and game-over; returns at OVER cycle 0.
  task automatic overTick();
    @(negedge master_clk);
    hitApple = 1'b1; gameOverFlag = 1'b1; BALL_clk = 1'b1;
    repeat (3) @(negedge master_clk);
  endtask

  initial begin
    int lowCnt;
    vecs[0] = '{1'b1, 1'b0, 3'd2, 8'd1, 3'd1};
    vecs[1] = '{1'b1, 1'b0, 3'd2, 8'd2, 3'd1};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 8'd3, 3'd1};
    vecs[3] = '{1'b1, 1'b0, 3'd2, 8'd4, 3'd1};
    vecs[4] = '{1'b1, 1'b0, 3'd2, 8'd5, 3'd2};
    vecs[5] = '{1'b0, 1'b0, 3'd2, 8'd5, 3'd2};
    vecs[6] = '{1'b1, 1'b0, 3'd2, 8'd6, 3'd2};

    rst = 1'b0;
    startButton = 1'b0; pauseButton = 1'b0; BALL_clk = 1'b0;
    hitApple = 1'b0; gameOverFlag = 1'b0;
    repeat (3) @(negedge master_clk);
    check("rst_state", gameState, 0);
    check("rst_startGame", startGame, 0);
    check("rst_gameRst_n", gameRst_n, 1);
    check("rst_speed", Speed, 1);
    check("rst_score", score, 0);
    check("rst_highScore", highScore, 0);
    rst = 1'b1;
    repeat (3) @(negedge master_clk);
    check("idle_after_rst", gameState, 0);

    pressStart();
    check("clear_entry_state", gameState, 1);
    countClear(lowCnt);
    check("clear_pulse_len", lowCnt, 4);
    check("play_state", gameState, 2);
    check("play_startGame", startGame, 1);
    check("play_score0", score, 0);
    check("play_speed1", Speed, 1);

    for (int i = 0; i < 7; i++) begin
      frame(vecs[i].hit, vecs[i].over);
      check($sformatf("vec%0d_state", i), gameState, vecs[i].expState);
      check($sformatf("vec%0d_score", i), score, vecs[i].expScore);
      check($sformatf("vec%0d_speed", i), Speed, vecs[i].expSpeed);
    end

    // Held pause: one entry only, ticks ignored while paused.
    @(negedge master_clk) pauseButton = 1'b1;
    repeat (10) @(negedge master_clk);
    check("pause_held_state", gameState, 3);
    check("pause_startGame", startGame, 0);
    pauseButton = 1'b0;
    frame(1'b1, 1'b0);
    check("pause_tick_ignored", score, 6);
    check("pause_state_kept", gameState, 3);
    pressPause();
    check("unpause_state", gameState, 2);
    check("unpause_score", score, 6);
    check("unpause_speed", Speed, 2);

    // Pause edge coincident with a counted apple tick.
    @(negedge master_clk) BALL_clk = 1'b1; hitApple = 1'b1;
    @(negedge master_clk);
    @(negedge master_clk) pauseButton = 1'b1;
    @(negedge master_clk);
    check("coinc_state", gameState, 3);
    check("coinc_score", score, 7);
    pauseButton = 1'b0; BALL_clk = 1'b0;
    repeat (3) @(negedge master_clk);
    pressStart();
    check("pause_start_resume", gameState, 2);
    pressStart();
    check("play_start_ignored", gameState, 2);

    for (int i = 0; i < 28; i++) frame(1'b1, 1'b0);
    check("apples35_score", score, 35);
    check("apples35_speed", Speed, 7);
    for (int i = 0; i < 265; i++) frame(1'b1, 1'b0);
    check("apples300_score", score, 255);
    check("apples300_speed", Speed, 7);

    overTick();
    check("over_state", gameState, 4);
    check("over_score", score, 255);
    check("over_highScore", highScore, 255);
    check("over_startGame", startGame, 0);
    BALL_clk = 1'b0; gameOverFlag = 1'b0; hitApple = 1'b0;
    repeat (9) @(negedge master_clk);
    pressStart();
    check("over_early_start", gameState, 4);
    repeat (14) @(negedge master_clk);
    pressStart();
    check("over_late_start", gameState, 1);
    check("restart_score", score, 0);
    check("restart_speed", Speed, 1);
    check("restart_highScore", highScore, 255);
    countClear(lowCnt);
    check("restart_pulse_len", lowCnt, 4);

    frame(1'b1, 1'b0);
    check("game2_score", score, 1);
    overTick();
    check("game2_over_state", gameState, 4);
    check("game2_highScore_kept", highScore, 255);
    BALL_clk = 1'b0; gameOverFlag = 1'b0; hitApple = 1'b0;
    repeat (25) @(negedge master_clk);
    pressStart();
    check("midclear_gameRst_n_low", gameRst_n, 0);

    rst = 1'b0;
    #1;
    check("midclear_rst_gameRst_n", gameRst_n, 1);
    check("midclear_rst_state", gameState, 0);
    check("midclear_rst_highScore", highScore, 0);
    @(negedge master_clk) rst = 1'b1;
    repeat (4) @(negedge master_clk);
    check("post_rst_state", gameState, 0);
    check("post_rst_gameRst_n", gameRst_n, 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
